lb_frame_sequencer: RTL and testbench

//  Sequencer for one line-buffer instance: latches layer geometry from layer_code and counts

---
 rtl/lb_frame_sequencer.sv | 103 ++++++++++
 tb/tb_lb_frame_sequencer.sv | 115 +++++++++++
 2 files changed

// File: rtl/lb_frame_sequencer.sv
// lb_frame_sequencer: line-buffer sequencer; counts pixel position, drives RAM addr/wea/sel and window valid.
// Optional sticky protocol-error flag enabled by defining LB_ERR_CHK_EN.
module lb_frame_sequencer #(
   parameter int LC_bits       = 20,
   parameter int ADDR_bits     = 10,
   parameter int K_ROWS        = 3,
   parameter int extra_latency = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [LC_bits-1:0]   layer_code,
   input  logic                 valid,
   output logic                 ready,
   output logic [ADDR_bits-1:0] addr,
   output logic                 wea,
   output logic                 sel,
   output logic                 out_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
   localparam int FCW    = extra_latency > 1 ? $clog2(extra_latency) : 1;
   localparam int LAT_M1 = extra_latency > 0 ? extra_latency - 1 : 0;
   localparam state_t FRAME_ST = K_ROWS <= 1 ? RUN : FILL;
   localparam state_t END_ST   = extra_latency == 0 ? IDLE : FLUSH;
   state_t               r_state, w_state_nxt;
   logic [ADDR_bits-1:0] r_col, r_wm1, w_col_nxt, w_wm1_new;
   logic [9:0]           r_row, r_hm1, w_row_nxt, w_hm1_new, w_lc_w, w_lc_h;
   logic [FCW-1:0]       r_fcnt;
   logic                 r_sel, w_beat, w_wrap, w_last, w_tag, w_start_ok;
   assign w_lc_w     = layer_code[9:0];
   assign w_lc_h     = layer_code[19:10];
   assign w_wm1_new  = ADDR_bits'(w_lc_w == 10'd0 ? 10'd0 : w_lc_w - 10'd1);
   assign w_hm1_new  = w_lc_h == 10'd0 ? 10'd0 : w_lc_h - 10'd1;
   assign ready      = (r_state == FILL) || (r_state == RUN);
   assign w_beat     = valid & ready;
   assign wea        = w_beat;
   assign addr       = r_col;
   assign sel        = r_sel;
   assign w_wrap     = w_beat && (r_col == r_wm1);
   assign w_last     = w_wrap && (r_row == r_hm1);
   assign w_tag      = w_beat && (r_row >= 10'(K_ROWS - 1));
   assign done       = extra_latency == 0 ? w_last : (r_state == FLUSH) && (r_fcnt == FCW'(LAT_M1));
   assign busy       = (r_state != IDLE) && !done;
   assign w_start_ok = start && ((r_state == IDLE) || done);
   assign w_col_nxt  = w_start_ok ? '0 : w_wrap ? '0 : w_beat ? r_col + 1'b1 : r_col;
   assign w_row_nxt  = w_start_ok ? '0 : w_wrap ? r_row + 10'd1 : r_row;
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:  w_state_nxt = IDLE;
         FILL:  w_state_nxt = w_last ? END_ST : (w_wrap && (r_row + 10'd1 == 10'(K_ROWS - 1))) ? RUN : FILL;
         RUN:   w_state_nxt = w_last ? END_ST : RUN;
         FLUSH: w_state_nxt = done ? IDLE : FLUSH;
         default: w_state_nxt = IDLE;
      endcase
      if (w_start_ok) w_state_nxt = FRAME_ST;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_col   <= '0;
         r_row   <= '0;
         r_wm1   <= '0;
         r_hm1   <= '0;
         r_fcnt  <= '0;
         r_sel   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_col   <= w_col_nxt;
         r_row   <= w_row_nxt;
         r_wm1   <= w_start_ok ? w_wm1_new : r_wm1;
         r_hm1   <= w_start_ok ? w_hm1_new : r_hm1;
         r_fcnt  <= r_state == FLUSH ? r_fcnt + 1'b1 : '0;
         r_sel   <= ((w_state_nxt == FILL) || (w_state_nxt == RUN)) && (w_row_nxt != 10'd0);
      end
   end
   // Window tag travels with the datapath so out_valid lines up with the pixel it describes.
   generate
      if (extra_latency == 0) begin : g_nodly
         assign out_valid = w_tag;
      end else begin : g_dly
         logic [extra_latency-1:0] r_dly;
         always_ff @(posedge clk) begin
            if (reset) r_dly <= '0;
            else       r_dly <= (r_dly << 1) | extra_latency'(w_tag);
         end
         assign out_valid = r_dly[extra_latency-1];
      end
   endgenerate
`ifdef LB_ERR_CHK_EN
   logic r_err;
   always_ff @(posedge clk) begin
      if (reset) r_err <= 1'b0;
      else       r_err <= r_err | (valid & ~ready) | (start & busy);
   end
   assign err = r_err;
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_lb_frame_sequencer.sv
// tb_lb_frame_sequencer: randomized + directed bench against a beat-index reference model.
module tb_lb_frame_sequencer;
   localparam int LAT = 5;
   localparam int K   = 3;
   logic        clk = 1'b0;
   logic        reset, start, valid;
   logic [19:0] layer_code;
   logic        ready, wea, sel, out_valid, busy, done, err;
   logic [9:0]  addr;
   int          n_chk = 0, n_fail = 0, cyc = 0;
   int          m_w, m_h, m_k, m_done_cyc;
   bit          m_active, m_inframe;
   bit          ov_at[int];
   always #5 clk = ~clk;
   lb_frame_sequencer #(.LC_bits(20), .ADDR_bits(10), .K_ROWS(K), .extra_latency(LAT)) dut (
      .clk(clk), .reset(reset), .start(start), .layer_code(layer_code), .valid(valid),
      .ready(ready), .addr(addr), .wea(wea), .sel(sel), .out_valid(out_valid),
      .busy(busy), .done(done), .err(err)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask
   task automatic model_reset();
      m_w = 1; m_h = 1; m_k = 0; m_active = 0; m_inframe = 0; m_done_cyc = -1;
      ov_at.delete();
   endtask
   function automatic logic [19:0] lc(input int w, input int h);
      logic [9:0] wv, hv;
      wv = 10'(w);
      hv = 10'(h);
      return {hv, wv};
   endfunction
   // One clock cycle: drive inputs, check this cycle's outputs, then advance the model past the edge.
   task automatic step(input bit r, input bit s, input bit v, input logic [19:0] code);
      bit e_done;
      @(negedge clk);
      reset = r; start = s; valid = v; layer_code = code;
      #1;
      e_done = (cyc == m_done_cyc);
      check("ready", ready, m_active);
      check("wea", wea, v && m_active);
      check("addr", addr, m_k % m_w);
      check("sel", sel, m_active && (m_k / m_w >= 1));
      check("out_valid", out_valid, ov_at.exists(cyc));
      check("done", done, e_done);
      check("busy", busy, m_inframe && !e_done);
      check("err", err, 0);
      if (r) model_reset();
      else begin
         if (v && m_active) begin
            if (m_k / m_w >= K - 1) ov_at[cyc + LAT] = 1;
            m_k++;
            if (m_k == m_w * m_h) begin
               m_active = 0;
               m_done_cyc = cyc + LAT;
            end
         end
         if (e_done) m_inframe = 0;
         if (s && !m_inframe) begin
            m_w = code[9:0] == 0 ? 1 : int'(code[9:0]);
            m_h = code[19:10] == 0 ? 1 : int'(code[19:10]);
            m_k = 0; m_active = 1; m_inframe = 1;
         end
      end
      cyc++;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 20'd0);
   endtask
   initial begin
      reset = 1; start = 0; valid = 0; layer_code = '0;
      repeat (3) @(posedge clk);
      model_reset();
      idle(2);
      step(0, 1, 0, lc(4, 4));
      for (int i = 0; i < 7; i++) step(0, 0, 1, 20'd0);
      step(1, 0, 1, 20'd0);
      idle(10);
      step(0, 1, 0, lc(4, 4));
      for (int i = 0; i < 16; i++) step(0, 0, 1, 20'd0);
      idle(8);
      step(0, 1, 0, lc(4, 2));
      for (int i = 0; i < 8; i++) step(0, 0, 1, 20'd0);
      idle(8);
      step(0, 1, 0, lc(3, 3));
      for (int i = 0; i < 18; i++) step(0, 0, i % 2 == 0, 20'd0);
      idle(8);
      step(0, 1, 0, lc(4, 4));
      for (int i = 0; i < 6; i++) step(0, 0, 1, 20'd0);
      step(0, 1, 1, lc(7, 2));
      for (int i = 0; i < 9; i++) step(0, 0, 1, 20'd0);
      idle(8);
      step(0, 1, 0, lc(2, 2));
      for (int i = 0; i < 4; i++) step(0, 0, 1, 20'd0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, lc(3, 2));
      for (int i = 0; i < 6; i++) step(0, 0, 1, 20'd0);
      idle(8);
      for (int f = 0; f < 25; f++) begin
         int p;
         p = $urandom_range(1, 4);
         step(0, 1, 0, lc($urandom_range(0, 6), $urandom_range(0, 5)));
         for (int i = 0; i < 400 && m_inframe; i++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) < p,
                 lc($urandom_range(0, 6), $urandom_range(0, 5)));
         idle($urandom_range(0, 3));
      end
      idle(4);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
